spi_slave_tx: RTL and testbench
===============================

Name: spi_slave_tx

Overview:
- SPI mode-0 slave transmitter. Drives MISO as the return path of the existing MOSI slave receiver, sharing the same SS/SCLK pads.
- Shifts a DATA_WIDTH-bit word MSB-first while SS is low. Supports back-to-back words within one SS-low frame (streaming).
- Sends IDLE_WORD and flags underrun when no word is supplied.
- Sits between the pad ring and the SoC-side register that provides readback data.

Parameters:
- DATA_WIDTH, 32, word length in bits; must be a power of 2, at least 8.
- IDLE_WORD, 32'h00000000, word shifted out when tx_valid is low at word start.
- CNT_W, $clog2(DATA_WIDTH), bit-counter width (derived; do not override).

Ports:
- reset  input  1  asynchronous, active-low reset.
- SCLK  input  1  SPI serial clock from master (clock); idle low (mode 0).
- SS  input  1  slave select, active low; high also acts as asynchronous frame clear.
- tx_data  input  DATA_WIDTH  word to transmit; must be stable from SS fall (or previous word_done) to the next SCLK falling edge.
- tx_valid  input  1  tx_data holds a fresh word.
- MISO  output  1  serial data to master.
- miso_oe  output  1  pad output enable; equals ~SS.
- tx_ack  output  1  high for one SCLK period after a valid word is captured.
- word_done  output  1  high for one SCLK period after the last bit of a word has been sampled.
- tx_underrun  output  1  sticky; set when IDLE_WORD was substituted; cleared at next frame start (SS fall) or reset.
- busy  output  1  high while a word is partially shifted (bit_cnt != 0).

Behaviour:
- Reset (reset=0, asynchronous): shift_reg=0, bit_cnt=0, tx_ack=0, word_done=0, tx_underrun=0. MISO=0 and miso_oe=0 provided SS is high.
- SS high: bit_cnt, shift_reg, tx_ack and word_done are asynchronously cleared to 0. miso_oe=0 and MISO=0. tx_underrun is held.
- Sequential state is updated on SCLK falling edges only. The master samples MISO on rising edges.
- MISO (combinational) while SS=0:
  - bit_cnt==0 → src[DATA_WIDTH-1], where src = tx_valid ? tx_data : IDLE_WORD.
  - otherwise → shift_reg[DATA_WIDTH-1].
- Falling edge with SS=0 and bit_cnt==0 (LOAD):
  - shift_reg <= src<<1, bit_cnt <= 1.
  - tx_ack <= tx_valid; tx_underrun <= tx_underrun | ~tx_valid.
  - word_done <= 0.
- Falling edge with SS=0 and 0<bit_cnt<DATA_WIDTH-1 (SHIFT):
  - shift_reg <= shift_reg<<1, bit_cnt++.
  - tx_ack <= 0, word_done <= 0.
- Falling edge with SS=0 and bit_cnt==DATA_WIDTH-1 (WRAP):
  - bit_cnt <= 0, word_done <= 1, shift_reg <= 0.
  - The MSB of the next word appears on MISO combinationally, ready for the next rising edge.
- Effective states are IDLE (SS=1), LOAD_PENDING (bit_cnt==0, SS=0) and SHIFTING (bit_cnt>0).
  - IDLE → LOAD_PENDING on SS fall.
  - LOAD_PENDING → SHIFTING on a falling edge.
  - SHIFTING → LOAD_PENDING on a WRAP falling edge.
  - Any state → IDLE on SS rise.
- tx_underrun clear: on SS fall, tx_underrun is cleared. Implement this with a frame-start flag captured on the first falling edge of the frame, so the block contains no SS-falling-edge flop.
- Abort: SS rising mid-word discards the remaining bits immediately. No word_done is generated. The next frame starts with a fresh LOAD.
- Reset mid-frame has priority over SCLK and SS. All outputs return to their reset values at once.
- Extra SCLK pulses while SS=1 are ignored.
- Latency:
  - First bit: valid as soon as SS is low and tx_data is stable.
  - Bit k (k≥1): valid after falling edge k.

Test Plan:
- Reset, SS=0, tx_data=32'hA5A5F00F, tx_valid=1, 32 mode-0 clocks → master samples 0xA5A5F00F MSB-first; tx_ack high for the period after falling edge 1; word_done high after falling edge 32; tx_underrun=0.
- Single frame, tx_data=32'h12345678 then 32'hCAFEBABE presented after word_done, 64 clocks → samples 0x12345678 then 0xCAFEBABE; two tx_ack and two word_done pulses; busy=0 between words.
- tx_valid=0, IDLE_WORD=32'hDEADBEEF, 32 clocks → samples 0xDEADBEEF; tx_ack never asserts; tx_underrun=1 after falling edge 1 and stays 1 after SS rise; next frame with tx_valid=1 clears it.
- 10 clocks of 32'hFFFF0000, then SS high, then new frame with 32'h0F0F0F0F for 32 clocks → first frame gives 10 ones, miso_oe=0 and bit_cnt=0 immediately at SS rise; second frame samples 0x0F0F0F0F exactly.
- reset pulsed low at bit 17 of an active frame → MISO, tx_ack, word_done, busy and tx_underrun go to 0 asynchronously; after reset release, a full frame of 32'h00000001 is received correctly.
- SS high with 8 SCLK pulses → MISO=0, miso_oe=0, no tx_ack or word_done, counter stays 0.

Source files
------------

// File: rtl/spi_slave_tx.sv
// SPI mode-0 slave transmitter: shifts words MSB-first on MISO while SS is low,
// streaming back-to-back words and substituting IDLE_WORD (flagging underrun) when no word is offered.
module spi_slave_tx #(
    parameter int                  DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD = 32'h00000000,
    parameter int                  CNT_W      = $clog2(DATA_WIDTH)
) (
    input  logic                  reset,
    input  logic                  SCLK,
    input  logic                  SS,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  MISO,
    output logic                  miso_oe,
    output logic                  tx_ack,
    output logic                  word_done,
    output logic                  tx_underrun,
    output logic                  busy
);

    logic [DATA_WIDTH-1:0] shift_r;
    logic [CNT_W-1:0]      bit_cnt_r;
    logic                  tx_ack_r;
    logic                  word_done_r;
    logic                  underrun_r;
    logic                  in_frame_r;
    logic [DATA_WIDTH-1:0] src_s;
    logic                  load_s;
    logic                  wrap_s;
    logic                  miso_s;

    // Word source and shift-phase decode
    always_comb begin
        src_s  = tx_valid ? tx_data : IDLE_WORD;
        load_s = (bit_cnt_r == {CNT_W{1'b0}});
        wrap_s = (bit_cnt_r == CNT_W'(DATA_WIDTH - 1));
        if (SS || !reset) begin
            miso_s = 1'b0;
        end else if (load_s) begin
            // First bit of each word goes out before any falling edge has loaded it.
            miso_s = src_s[DATA_WIDTH-1];
        end else begin
            miso_s = shift_r[DATA_WIDTH-1];
        end
    end

    // Shift datapath; SS high aborts the frame asynchronously
    always_ff @(negedge SCLK or negedge reset or posedge SS) begin
        if (!reset || SS) begin
            shift_r     <= {DATA_WIDTH{1'b0}};
            bit_cnt_r   <= {CNT_W{1'b0}};
            tx_ack_r    <= 1'b0;
            word_done_r <= 1'b0;
            in_frame_r  <= 1'b0;
        end else begin
            in_frame_r <= 1'b1;
            if (load_s) begin
                shift_r     <= src_s << 1;
                bit_cnt_r   <= CNT_W'(1);
                tx_ack_r    <= tx_valid;
                word_done_r <= 1'b0;
            end else if (wrap_s) begin
                shift_r     <= {DATA_WIDTH{1'b0}};
                bit_cnt_r   <= {CNT_W{1'b0}};
                tx_ack_r    <= 1'b0;
                word_done_r <= 1'b1;
            end else begin
                shift_r     <= shift_r << 1;
                bit_cnt_r   <= bit_cnt_r + CNT_W'(1);
                tx_ack_r    <= 1'b0;
                word_done_r <= 1'b0;
            end
        end
    end

    // Sticky underrun survives SS high; the first edge of a frame restarts it from zero
    always_ff @(negedge SCLK or negedge reset) begin
        if (!reset) begin
            underrun_r <= 1'b0;
        end else if (!SS && load_s) begin
            underrun_r <= (in_frame_r ? underrun_r : 1'b0) | ~tx_valid;
        end else begin
            underrun_r <= underrun_r;
        end
    end

    assign MISO        = miso_s;
    assign miso_oe     = ~SS;
    assign tx_ack      = tx_ack_r;
    assign word_done   = word_done_r;
    assign tx_underrun = underrun_r;
    assign busy        = (bit_cnt_r != {CNT_W{1'b0}});

endmodule

// File: tb/tb_spi_slave_tx.sv
// Directed bench for spi_slave_tx acting as a mode-0 SPI master with a word scoreboard.
module tb_spi_slave_tx;

    logic        reset;
    logic        SCLK;
    logic        SS;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        MISO;
    logic        miso_oe;
    logic        tx_ack;
    logic        word_done;
    logic        tx_underrun;
    logic        busy;

    int          checks;
    int          failures;
    logic [31:0] exp_q[$];
    logic [31:0] rx_word;
    int          rx_bits;
    int          edge_n;
    int          ack_cnt;
    int          done_cnt;
    int          first_ack_edge;
    int          last_done_edge;

    spi_slave_tx #(
        .DATA_WIDTH(32),
        .IDLE_WORD (32'hDEADBEEF)
    ) dut (
        .reset      (reset),
        .SCLK       (SCLK),
        .SS         (SS),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .MISO       (MISO),
        .miso_oe    (miso_oe),
        .tx_ack     (tx_ack),
        .word_done  (word_done),
        .tx_underrun(tx_underrun),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        edge_n = 0; ack_cnt = 0; done_cnt = 0;
        first_ack_edge = 0; last_done_edge = 0;
    endtask

    // One mode-0 bit: master samples MISO at the rising edge, slave updates at the falling edge.
    task automatic pulse(input bit rx_en);
        #2;
        if (rx_en) begin
            rx_word = {rx_word[30:0], MISO};
            rx_bits++;
            if (rx_bits == 32) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_word", rx_word, 32'hXXXXXXXX);
                end else begin
                    check("sb_word", rx_word, exp_q.pop_front());
                end
                rx_bits = 0;
            end
        end
        SCLK = 1'b1;
        #5;
        SCLK = 1'b0;
        #3;
        edge_n++;
        if (tx_ack === 1'b1) begin
            ack_cnt++;
            if (first_ack_edge == 0) first_ack_edge = edge_n;
        end
        if (word_done === 1'b1) begin
            done_cnt++;
            last_done_edge = edge_n;
        end
    endtask

    task automatic pulses(input int n, input bit rx_en);
        for (int i = 0; i < n; i++) pulse(rx_en);
    endtask

    initial begin
        checks = 0; failures = 0; rx_word = 32'h0; rx_bits = 0;
        reset = 1'b0; SCLK = 1'b0; SS = 1'b1; tx_data = 32'h0; tx_valid = 1'b0;
        clear_stats();
        #10;
        check("rst_miso", {31'h0, MISO}, 32'h0);
        check("rst_oe", {31'h0, miso_oe}, 32'h0);
        check("rst_ack", {31'h0, tx_ack}, 32'h0);
        check("rst_done", {31'h0, word_done}, 32'h0);
        check("rst_underrun", {31'h0, tx_underrun}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        reset = 1'b1;
        #5;

        // Single word
        tx_data = 32'hA5A5F00F; tx_valid = 1'b1; exp_q.push_back(32'hA5A5F00F);
        SS = 1'b0; #5;
        check("t1_oe", {31'h0, miso_oe}, 32'h1);
        pulses(32, 1'b1);
        check("t1_ack_cnt", ack_cnt, 32'd1);
        check("t1_ack_edge", first_ack_edge, 32'd1);
        check("t1_done_cnt", done_cnt, 32'd1);
        check("t1_done_edge", last_done_edge, 32'd32);
        check("t1_underrun", {31'h0, tx_underrun}, 32'h0);
        SS = 1'b1; #5;
        clear_stats();

        // Streaming two words in one frame
        tx_data = 32'h12345678; exp_q.push_back(32'h12345678);
        SS = 1'b0; #5;
        pulses(32, 1'b1);
        check("t2_busy_gap", {31'h0, busy}, 32'h0);
        check("t2_done_gap", {31'h0, word_done}, 32'h1);
        tx_data = 32'hCAFEBABE; exp_q.push_back(32'hCAFEBABE);
        pulses(32, 1'b1);
        check("t2_ack_cnt", ack_cnt, 32'd2);
        check("t2_done_cnt", done_cnt, 32'd2);
        SS = 1'b1; #5;
        clear_stats();

        // Underrun: IDLE_WORD substituted
        tx_valid = 1'b0; tx_data = 32'h11111111; exp_q.push_back(32'hDEADBEEF);
        SS = 1'b0; #5;
        pulse(1'b1);
        check("t3_underrun_set", {31'h0, tx_underrun}, 32'h1);
        pulses(31, 1'b1);
        check("t3_ack_cnt", ack_cnt, 32'd0);
        SS = 1'b1; #5;
        check("t3_underrun_held", {31'h0, tx_underrun}, 32'h1);
        clear_stats();

        // Abort after 10 bits, then a clean frame
        tx_valid = 1'b1; tx_data = 32'hFFFF0000; rx_word = 32'h0;
        SS = 1'b0; #5;
        pulse(1'b1);
        check("t4_underrun_clr", {31'h0, tx_underrun}, 32'h0);
        pulses(9, 1'b1);
        check("t4_partial", {22'h0, rx_word[9:0]}, 32'h3FF);
        SS = 1'b1; #1;
        check("t4_abort_oe", {31'h0, miso_oe}, 32'h0);
        check("t4_abort_busy", {31'h0, busy}, 32'h0);
        check("t4_abort_miso", {31'h0, MISO}, 32'h0);
        rx_bits = 0; #4;
        tx_data = 32'h0F0F0F0F; exp_q.push_back(32'h0F0F0F0F);
        SS = 1'b0; #5;
        pulses(32, 1'b1);
        SS = 1'b1; #5;
        clear_stats();

        // Reset mid-frame at bit 17
        tx_valid = 1'b0; tx_data = 32'h0;
        SS = 1'b0; #5;
        pulses(17, 1'b1);
        check("t5_busy_pre", {31'h0, busy}, 32'h1);
        check("t5_underrun_pre", {31'h0, tx_underrun}, 32'h1);
        reset = 1'b0; #1;
        check("t5_miso", {31'h0, MISO}, 32'h0);
        check("t5_ack", {31'h0, tx_ack}, 32'h0);
        check("t5_done", {31'h0, word_done}, 32'h0);
        check("t5_busy", {31'h0, busy}, 32'h0);
        check("t5_underrun", {31'h0, tx_underrun}, 32'h0);
        rx_bits = 0;
        SS = 1'b1; #4; reset = 1'b1; #5;
        tx_valid = 1'b1; tx_data = 32'h00000001; exp_q.push_back(32'h00000001);
        SS = 1'b0; #5;
        pulses(32, 1'b1);
        SS = 1'b1; #5;
        clear_stats();

        // Clocks while deselected are ignored
        tx_data = 32'hFFFFFFFF;
        pulses(8, 1'b0);
        check("t6_miso", {31'h0, MISO}, 32'h0);
        check("t6_oe", {31'h0, miso_oe}, 32'h0);
        check("t6_ack_cnt", ack_cnt, 32'd0);
        check("t6_done_cnt", done_cnt, 32'd0);
        check("t6_busy", {31'h0, busy}, 32'h0);

        check("sb_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
